// File: rtl/io_map_pkg.sv
// io_map_pkg: shared IO address map and scan encodings for io_scan_ctrl.
//   ADDR_*   IO word addresses decoded on IOAddr
//   SEG_OFF  segment pattern with every segment dark (active-low)
//   AN_OFF   anode pattern with every digit disabled (active-low)
//   scan_state_e  scan sequencer state encoding
package io_map_pkg;

    localparam logic [3:0] ADDR_DISP = 4'h0;
    localparam logic [3:0] ADDR_CTRL = 4'h1;
    localparam logic [3:0] ADDR_SW   = 4'h4;
    localparam logic [3:0] ADDR_DIR  = 4'h8;
    localparam logic [3:0] ADDR_STAT = 4'hC;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [3:0] AN_OFF  = 4'hF;

    typedef enum logic [1:0] {
        SCAN_OFF   = 2'd0,
        SCAN_SHOW  = 2'd1,
        SCAN_BLANK = 2'd2
    } scan_state_e;

    // Active-low one-hot anode enable for digit idx.
    function automatic logic [3:0] an_sel(input logic [1:0] idx);
        logic [3:0] onehot;
        onehot = 4'b0001 << idx;
        return ~onehot;
    endfunction

endpackage

// File: rtl/io_debounce.sv
// io_debounce: two-flop synchroniser followed by a stability counter.
//   clk_i   system clock
//   rst_ni  asynchronous active-low reset
//   raw_i   asynchronous raw inputs (W bits, treated as one group)
//   db_o    debounced value, updates once the synchronised input has held a
//           new value for 2**DEB_BITS cycles
module io_debounce #(
    parameter int W        = 1,
    parameter int DEB_BITS = 16
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [W-1:0] raw_i,
    output logic [W-1:0] db_o
);

    localparam logic [DEB_BITS-1:0] CNT_ONE = {{(DEB_BITS-1){1'b0}}, 1'b1};

    logic [W-1:0]        sync1_q, sync2_q, cand_q, db_q, db_d;
    logic [DEB_BITS-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= '0;
            sync2_q <= '0;
            cand_q  <= '0;
            cnt_q   <= '0;
            db_q    <= '0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            cand_q  <= sync2_q;
            cnt_q   <= cnt_d;
            db_q    <= db_d;
        end
    end

    // cand_q is the previous synchronised sample: any movement restarts the
    // count, and nothing counts while the candidate equals the accepted value.
    always_comb begin
        cnt_d = cnt_q;
        db_d  = db_q;
        if ((sync2_q != cand_q) || (cand_q == db_q)) begin
            cnt_d = '0;
        end else if (&cnt_q) begin
            db_d  = cand_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    assign db_o = db_q;

endmodule

// File: rtl/io_scan_ctrl.sv
// io_scan_ctrl: memory-mapped IO block for the MIPS IO port.
//   CLK, RESET_N           clock, asynchronous active-low reset
//   IOAddr, IOWriteData,   processor IO write port (one-cycle strobe)
//   IOWriteEn
//   IOReadData             read data, combinational from registered state
//   SW_IN, DIR_IN          raw switches, debounced internally
//   LED, AN                registered 7-segment drive, active-low
//
// state | meaning
// OFF   | display disabled; outputs dark, idx and dwell counter held at 0
// SHOW  | digit idx driven for 2**SCAN_BITS cycles; the first dwell after
//       | reset or OFF is kept dark (lit_q=0) so the first digit appears
//       | one full dwell later
// BLANK | all anodes off for BLANK_CYCLES cycles between digits
module io_scan_ctrl
    import io_map_pkg::*;
#(
    parameter int SCAN_BITS    = 14,
    parameter int BLANK_CYCLES = 64,
    parameter int DEB_BITS     = 16
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic [3:0]  IOAddr,
    input  logic [31:0] IOWriteData,
    input  logic        IOWriteEn,
    output logic [31:0] IOReadData,
    input  logic [1:0]  SW_IN,
    input  logic        DIR_IN,
    output logic [6:0]  LED,
    output logic [3:0]  AN
);

    localparam int BLANK_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam int CNT_W   = (SCAN_BITS > BLANK_W) ? SCAN_BITS : BLANK_W;

    localparam logic [CNT_W-1:0] DWELL_TC = CNT_W'((2 ** SCAN_BITS) - 1);
    localparam logic [CNT_W-1:0] BLANK_TC = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    scan_state_e      state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             lit_q, lit_d;
    logic [27:0]      shadow_q, shadow_d;
    logic [27:0]      active_q, active_d;
    logic [7:0]       frame_q, frame_d;
    logic             disp_en_q, disp_en_d;
    logic             blank_en_q, blank_en_d;
    logic [6:0]       led_q, led_d;
    logic [3:0]       an_q, an_d;

    logic             wr_disp, wr_ctrl, advance;
    logic [6:0]       digit;
    logic [1:0]       sw_db;
    logic             dir_db;
    logic             unused_wdata;

    assign unused_wdata = ^IOWriteData[31:28];

    io_debounce #(.W(2), .DEB_BITS(DEB_BITS)) u_deb_sw (
        .clk_i  (CLK),
        .rst_ni (RESET_N),
        .raw_i  (SW_IN),
        .db_o   (sw_db)
    );

    io_debounce #(.W(1), .DEB_BITS(DEB_BITS)) u_deb_dir (
        .clk_i  (CLK),
        .rst_ni (RESET_N),
        .raw_i  (DIR_IN),
        .db_o   (dir_db)
    );

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= SCAN_SHOW;
            idx_q      <= '0;
            cnt_q      <= '0;
            lit_q      <= 1'b0;
            shadow_q   <= '0;
            active_q   <= '0;
            frame_q    <= '0;
            disp_en_q  <= 1'b1;
            blank_en_q <= 1'b1;
            led_q      <= SEG_OFF;
            an_q       <= AN_OFF;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            lit_q      <= lit_d;
            shadow_q   <= shadow_d;
            active_q   <= active_d;
            frame_q    <= frame_d;
            disp_en_q  <= disp_en_d;
            blank_en_q <= blank_en_d;
            led_q      <= led_d;
            an_q       <= an_d;
        end
    end

    // Register writes. shadow_d is used below as the frame-boundary source,
    // so a display write landing on the boundary cycle goes straight to active.
    always_comb begin
        wr_disp    = IOWriteEn && (IOAddr == ADDR_DISP);
        wr_ctrl    = IOWriteEn && (IOAddr == ADDR_CTRL);
        shadow_d   = wr_disp ? IOWriteData[27:0] : shadow_q;
        disp_en_d  = wr_ctrl ? IOWriteData[0] : disp_en_q;
        blank_en_d = wr_ctrl ? IOWriteData[1] : blank_en_q;
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q + CNT_ONE;
        lit_d    = lit_q;
        active_d = active_q;
        frame_d  = frame_q;
        advance  = 1'b0;

        case (state_q)
            SCAN_OFF: begin
                cnt_d = '0;
                idx_d = '0;
                lit_d = 1'b0;
                if (disp_en_q) begin
                    state_d  = SCAN_SHOW;
                    active_d = shadow_d;
                end
            end
            SCAN_SHOW: begin
                if (cnt_q == DWELL_TC) begin
                    cnt_d = '0;
                    if (!lit_q) begin
                        lit_d = 1'b1;
                    end else if (blank_en_q) begin
                        state_d = SCAN_BLANK;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            SCAN_BLANK: begin
                // blank_en is only consulted on entry, so a blank in
                // progress always runs to completion.
                if (cnt_q == BLANK_TC) begin
                    cnt_d   = '0;
                    state_d = SCAN_SHOW;
                    advance = 1'b1;
                end
            end
            default: begin
                state_d = SCAN_OFF;
            end
        endcase

        if (advance) begin
            idx_d = idx_q + 2'd1;
            if (idx_q == 2'd3) begin
                active_d = shadow_d;
                frame_d  = frame_q + 8'd1;
            end
        end

        if (!disp_en_q) begin
            state_d  = SCAN_OFF;
            idx_d    = '0;
            cnt_d    = '0;
            lit_d    = 1'b0;
            active_d = active_q;
            frame_d  = frame_q;
        end
    end

    always_comb begin
        case (idx_q)
            2'd1:    digit = active_q[13:7];
            2'd2:    digit = active_q[20:14];
            2'd3:    digit = active_q[27:21];
            default: digit = active_q[6:0];
        endcase
    end

    always_comb begin
        led_d = SEG_OFF;
        an_d  = AN_OFF;
        if ((state_q == SCAN_SHOW) && lit_q) begin
            an_d  = an_sel(idx_q);
            led_d = ~digit;
        end
    end

    assign LED = led_q;
    assign AN  = an_q;

    always_comb begin
        case (IOAddr)
            ADDR_SW:   IOReadData = {30'b0, sw_db};
            ADDR_DIR:  IOReadData = dir_db ? 32'h0000_0004 : 32'hFFFF_FFFC;
            ADDR_STAT: IOReadData = {22'b0, disp_en_q, blank_en_q, frame_q};
            default:   IOReadData = 32'h0;
        endcase
    end

endmodule
